ram_arbiter: RTL and testbench

- Two-requester arbiter sharing one single-port synchronous RAM (1-cycle registered read, read-before-write).
- Requester 0 is typically the instruction-fetch path; requester 1 is the load/store path.
- Grants at most one access per cycle, round-robin between requesters, with optional bus lock for atomic read-modify-write sequences.
- Routes returned read data to the requester that issued the read.

---
 rtl/ram_arbiter_if.sv | 54 +++++
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the shared single-port RAM and
// ram_arbiter. The arbiter takes the slave modport; requesters and the RAM
// model take the master modport.
//
// Handshake: reqN_i acts as valid and gntN_o as ready. A transfer happens in
// exactly the cycle where reqN_i && gntN_o; until then the requester holds
// req/we/adr/dat/lock stable. gntN_o is combinational and may depend on
// reqN_i in the same cycle. Read data returns one cycle after the transfer,
// qualified by rvalidN_o, with no back-pressure.
interface ram_arbiter_if #(
  parameter int dat_width = 32,
  parameter int adr_width = 32
);
  logic                 req0_i;
  logic                 we0_i;
  logic                 lock0_i;
  logic [adr_width-1:0] adr0_i;
  logic [dat_width-1:0] dat0_i;
  logic                 gnt0_o;
  logic                 rvalid0_o;
  logic [dat_width-1:0] rdat0_o;

  logic                 req1_i;
  logic                 we1_i;
  logic                 lock1_i;
  logic [adr_width-1:0] adr1_i;
  logic [dat_width-1:0] dat1_i;
  logic                 gnt1_o;
  logic                 rvalid1_o;
  logic [dat_width-1:0] rdat1_o;

  logic [adr_width-1:0] ram_adr_o;
  logic [dat_width-1:0] ram_dat_o;
  logic                 ram_we_o;
  logic [dat_width-1:0] ram_dat_i;

  modport slave (
    input  req0_i, we0_i, lock0_i, adr0_i, dat0_i,
    input  req1_i, we1_i, lock1_i, adr1_i, dat1_i,
    input  ram_dat_i,
    output gnt0_o, rvalid0_o, rdat0_o,
    output gnt1_o, rvalid1_o, rdat1_o,
    output ram_adr_o, ram_dat_o, ram_we_o
  );

  modport master (
    output req0_i, we0_i, lock0_i, adr0_i, dat0_i,
    output req1_i, we1_i, lock1_i, adr1_i, dat1_i,
    output ram_dat_i,
    input  gnt0_o, rvalid0_o, rdat0_o,
    input  gnt1_o, rvalid1_o, rdat1_o,
    input  ram_adr_o, ram_dat_o, ram_we_o
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of one single-port synchronous RAM
// (1-cycle registered read, read-before-write). One access per cycle,
// round-robin on contention, optional lock so a requester can keep the RAM
// across a read-modify-write. Read data is steered back to the requester
// that issued the read, one cycle after the grant.
//
// Build option RAM_ARB_FIXED_PRIO_EN: requester 1 always wins contention in
// IDLE and the last-grant pointer is removed. Lock handling is unchanged.
//
// state_o exposes the FSM encoding: 0 = IDLE, 1 = OWN0, 2 = OWN1.
module ram_arbiter #(
  parameter int dat_width = 32,
  parameter int adr_width = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ram_arbiter_if.slave bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t               state;
  logic                 gnt0;
  logic                 gnt1;
  logic                 rvalid0;
  logic                 rvalid1;
  logic [adr_width-1:0] adr_mux;
  logic [dat_width-1:0] dat_mux;
  logic                 we_mux;

`ifndef RAM_ARB_FIXED_PRIO_EN
  // 1 when requester 1 took the most recent grant; reset to 1 so that
  // requester 0 wins the first contention.
  logic last_gnt;
`endif

  // Grant decision: the owner alone may be granted while locked; in IDLE a
  // lone request wins outright and contention goes to the other requester.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0_i && bus.req1_i) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          gnt1 = 1'b1;
`else
          if (last_gnt) gnt0 = 1'b1;
          else          gnt1 = 1'b1;
`endif
        end else begin
          gnt0 = bus.req0_i;
          gnt1 = bus.req1_i;
        end
      end
      OWN0:    gnt0 = bus.req0_i;
      OWN1:    gnt1 = bus.req1_i;
      default: begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
      end
    endcase
  end

  // RAM-side mux; requester 0 drives address/data when nobody is granted.
  always_comb begin
    if (gnt1) begin
      adr_mux = bus.adr1_i;
      dat_mux = bus.dat1_i;
      we_mux  = bus.we1_i;
    end else begin
      adr_mux = bus.adr0_i;
      dat_mux = bus.dat0_i;
      we_mux  = bus.we0_i & gnt0;
    end
  end

  // Ownership FSM and read-return tags; a read in flight is dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~bus.we0_i;
      rvalid1 <= gnt1 & ~bus.we1_i;
      case (state)
        IDLE: begin
          if (gnt0 && bus.lock0_i)      state <= OWN0;
          else if (gnt1 && bus.lock1_i) state <= OWN1;
        end
        OWN0: begin
          if ((gnt0 && !bus.lock0_i) || (!bus.lock0_i && !bus.req0_i))
            state <= IDLE;
        end
        OWN1: begin
          if ((gnt1 && !bus.lock1_i) || (!bus.lock1_i && !bus.req1_i))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  // Round-robin pointer follows every grant, locked or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end
`endif

  assign bus.gnt0_o    = gnt0;
  assign bus.gnt1_o    = gnt1;
  assign bus.rvalid0_o = rvalid0;
  assign bus.rvalid1_o = rvalid1;
  // RAM output register is the data register; route it straight through.
  assign bus.rdat0_o   = bus.ram_dat_i;
  assign bus.rdat1_o   = bus.ram_dat_i;
  assign bus.ram_adr_o = adr_mux;
  assign bus.ram_dat_o = dat_mux;
  assign bus.ram_we_o  = we_mux;
  assign state_o       = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM
// (registered read, read-before-write). Expected grant order follows the
// RAM_ARB_FIXED_PRIO_EN build option.
module tb_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_o;
  int         total;
  int         bad;

  ram_arbiter_if #(.dat_width(32), .adr_width(32)) bus ();

  ram_arbiter #(.dat_width(32), .adr_width(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // Clock and bounded run time
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (time=%0t, required < 200000)", $time);
    $fatal(1, "watchdog expired");
  end

  // RAM model: 256 words, registered read of the old contents, then write
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_we_o) mem[bus.ram_adr_o[7:0]] <= bus.ram_dat_o;
    bus.ram_dat_i <= mem[bus.ram_adr_o[7:0]];
  end

  // Driver tasks
  task automatic set_req0(input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
    bus.req0_i = r; bus.we0_i = w; bus.lock0_i = l; bus.adr0_i = a; bus.dat0_i = d;
  endtask

  task automatic set_req1(input logic r, input logic w, input logic l,
                          input logic [31:0] a, input logic [31:0] d);
    bus.req1_i = r; bus.we1_i = w; bus.lock1_i = l; bus.adr1_i = a; bus.dat1_i = d;
  endtask

  task automatic clear_reqs();
    set_req0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic apply_reset();
    clear_reqs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Reset state
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (bus.rvalid0_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid0 got=%b exp=0", bus.rvalid0_o); end
    total++; if (bus.rvalid1_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid1 got=%b exp=0", bus.rvalid1_o); end
    total++; if (bus.gnt0_o !== 1'b0 || bus.gnt1_o !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b%b exp=00", bus.gnt1_o, bus.gnt0_o); end
    @(posedge clk); #1;
  endtask

  // Single read from requester 0
  task automatic test_single_read();
    set_req0(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    total++; if (bus.gnt0_o !== 1'b1) begin bad++; $display("FAIL sr_gnt0 got=%b exp=1", bus.gnt0_o); end
    total++; if (bus.ram_adr_o !== 32'd5) begin bad++; $display("FAIL sr_adr got=%0d exp=5", bus.ram_adr_o); end
    total++; if (bus.ram_we_o !== 1'b0) begin bad++; $display("FAIL sr_we got=%b exp=0", bus.ram_we_o); end
    @(posedge clk); #1;
    clear_reqs();
    total++; if (bus.rvalid0_o !== 1'b1) begin bad++; $display("FAIL sr_rvalid0 got=%b exp=1", bus.rvalid0_o); end
    total++; if (bus.rdat0_o !== 32'hA5A5_0001) begin bad++; $display("FAIL sr_rdat0 got=%h exp=a5a50001", bus.rdat0_o); end
    total++; if (bus.rvalid1_o !== 1'b0) begin bad++; $display("FAIL sr_rvalid1 got=%b exp=0", bus.rvalid1_o); end
    @(posedge clk); #1;
  endtask

  // Both requesters read continuously; grants alternate (or stick to 1)
  task automatic test_contention();
    logic [3:0]  exp_g1;
    logic [31:0] exp_d;
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_g1 = 4'b1111;
`else
    exp_g1 = 4'b1010;  // bit k = requester 1 wins cycle k: 0,1,0,1
`endif
    apply_reset();
    set_req0(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    set_req1(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (bus.gnt1_o !== exp_g1[k] || bus.gnt0_o !== ~exp_g1[k])
        begin bad++; $display("FAIL cont_gnt cycle=%0d got=%b%b exp=%b%b", k, bus.gnt1_o, bus.gnt0_o, exp_g1[k], ~exp_g1[k]); end
      @(posedge clk); #1;
      exp_d = exp_g1[k] ? 32'h1000_0002 : 32'h1000_0001;
      total++; if (bus.rvalid1_o !== exp_g1[k] || bus.rvalid0_o !== ~exp_g1[k])
        begin bad++; $display("FAIL cont_rvalid cycle=%0d got=%b%b exp=%b%b", k, bus.rvalid1_o, bus.rvalid0_o, exp_g1[k], ~exp_g1[k]); end
      total++; if ((exp_g1[k] ? bus.rdat1_o : bus.rdat0_o) !== exp_d)
        begin bad++; $display("FAIL cont_rdat cycle=%0d got=%h exp=%h", k, exp_g1[k] ? bus.rdat1_o : bus.rdat0_o, exp_d); end
    end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  // Locked read-modify-write by requester 1 while requester 0 keeps asking
  task automatic test_lock_rmw();
    set_req0(1'b1, 1'b0, 1'b0, 32'd7, 32'd0);  // lone grant leaves pointer on 0
    @(negedge clk);
    total++; if (bus.gnt0_o !== 1'b1) begin bad++; $display("FAIL lk_pre_gnt0 got=%b exp=1", bus.gnt0_o); end
    @(posedge clk); #1;
    set_req0(1'b1, 1'b0, 1'b0, 32'd9, 32'd0);
    set_req1(1'b1, 1'b0, 1'b1, 32'd8, 32'd0);
    @(negedge clk);
    total++; if (bus.gnt1_o !== 1'b1 || bus.gnt0_o !== 1'b0) begin bad++; $display("FAIL lk_c1_gnt got=%b%b exp=10", bus.gnt1_o, bus.gnt0_o); end
    @(posedge clk); #1;
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL lk_own1 got=%0d exp=2", state_o); end
    total++; if (bus.rvalid1_o !== 1'b1 || bus.rdat1_o !== 32'h1000_0008) begin bad++; $display("FAIL lk_rd got=%b/%h exp=1/10000008", bus.rvalid1_o, bus.rdat1_o); end
    set_req1(1'b1, 1'b1, 1'b0, 32'd8, 32'h0000_0010);
    @(negedge clk);
    total++; if (bus.gnt1_o !== 1'b1 || bus.gnt0_o !== 1'b0) begin bad++; $display("FAIL lk_c2_gnt got=%b%b exp=10", bus.gnt1_o, bus.gnt0_o); end
    total++; if (bus.ram_we_o !== 1'b1 || bus.ram_dat_o !== 32'h0000_0010) begin bad++; $display("FAIL lk_c2_wr got=%b/%h exp=1/00000010", bus.ram_we_o, bus.ram_dat_o); end
    @(posedge clk); #1;
    total++; if (bus.rvalid1_o !== 1'b0) begin bad++; $display("FAIL lk_wr_rvalid got=%b exp=0", bus.rvalid1_o); end
    set_req1(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    total++; if (bus.gnt0_o !== 1'b1) begin bad++; $display("FAIL lk_c3_gnt0 got=%b exp=1", bus.gnt0_o); end
    @(posedge clk); #1;
    total++; if (bus.rvalid0_o !== 1'b1 || bus.rdat0_o !== 32'h1000_0009) begin bad++; $display("FAIL lk_c3_rd got=%b/%h exp=1/10000009", bus.rvalid0_o, bus.rdat0_o); end
    set_req0(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req1(1'b1, 1'b0, 1'b0, 32'd8, 32'd0);
    @(negedge clk);
    total++; if (bus.gnt1_o !== 1'b1) begin bad++; $display("FAIL lk_rb_gnt1 got=%b exp=1", bus.gnt1_o); end
    @(posedge clk); #1;
    total++; if (bus.rvalid1_o !== 1'b1 || bus.rdat1_o !== 32'h0000_0010) begin bad++; $display("FAIL lk_readback got=%b/%h exp=1/00000010", bus.rvalid1_o, bus.rdat1_o); end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  // Write followed immediately by a read of the same word
  task automatic test_write_then_read();
    set_req0(1'b1, 1'b1, 1'b0, 32'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    total++; if (bus.gnt0_o !== 1'b1 || bus.ram_we_o !== 1'b1) begin bad++; $display("FAIL wr_gnt_we got=%b/%b exp=1/1", bus.gnt0_o, bus.ram_we_o); end
    @(posedge clk); #1;
    total++; if (bus.rvalid0_o !== 1'b0) begin bad++; $display("FAIL wr_rvalid got=%b exp=0", bus.rvalid0_o); end
    set_req0(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
    @(negedge clk);
    total++; if (bus.ram_we_o !== 1'b0) begin bad++; $display("FAIL rd_we got=%b exp=0", bus.ram_we_o); end
    @(posedge clk); #1;
    total++; if (bus.rvalid0_o !== 1'b1 || bus.rdat0_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wtr_rdat got=%b/%h exp=1/deadbeef", bus.rvalid0_o, bus.rdat0_o); end
    clear_reqs();
    @(posedge clk); #1;
  endtask

  // No requests: nothing granted, nothing written, nothing returned
  task automatic test_idle();
    clear_reqs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (bus.gnt0_o !== 1'b0 || bus.gnt1_o !== 1'b0 || bus.ram_we_o !== 1'b0)
        begin bad++; $display("FAIL idle_bus cycle=%0d got gnt=%b%b we=%b exp=00/0", k, bus.gnt1_o, bus.gnt0_o, bus.ram_we_o); end
      total++; if (bus.rvalid0_o !== 1'b0 || bus.rvalid1_o !== 1'b0)
        begin bad++; $display("FAIL idle_rvalid cycle=%0d got=%b%b exp=00", k, bus.rvalid1_o, bus.rvalid0_o); end
    end
    @(posedge clk); #1;
  endtask

  // Reset while locked with a read in flight
  task automatic test_reset_mid_read();
    set_req0(1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    @(negedge clk);
    total++; if (bus.gnt0_o !== 1'b1) begin bad++; $display("FAIL rmr_gnt0 got=%b exp=1", bus.gnt0_o); end
    @(posedge clk); #1;
    total++; if (bus.rvalid0_o !== 1'b1 || state_o !== 2'd1) begin bad++; $display("FAIL rmr_pre got=%b/%0d exp=1/1", bus.rvalid0_o, state_o); end
    @(negedge clk);  // second read granted this cycle, then reset hits
    rst_n = 1'b0;
    #1;
    total++; if (bus.rvalid0_o !== 1'b0) begin bad++; $display("FAIL rmr_async_rvalid got=%b exp=0", bus.rvalid0_o); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rmr_async_state got=%0d exp=0", state_o); end
    clear_reqs();
    @(posedge clk); #1;
    total++; if (bus.rvalid0_o !== 1'b0) begin bad++; $display("FAIL rmr_discard got=%b exp=0", bus.rvalid0_o); end
    rst_n = 1'b1;
    set_req0(1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
    set_req1(1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
    total++; if (bus.gnt1_o !== 1'b1 || bus.gnt0_o !== 1'b0) begin bad++; $display("FAIL rmr_first got=%b%b exp=10", bus.gnt1_o, bus.gnt0_o); end
`else
    total++; if (bus.gnt0_o !== 1'b1 || bus.gnt1_o !== 1'b0) begin bad++; $display("FAIL rmr_first got=%b%b exp=01", bus.gnt1_o, bus.gnt0_o); end
`endif
    @(posedge clk); #1;
    clear_reqs();
    @(posedge clk); #1;
  endtask

  // Sequencer and final report
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    bus.ram_dat_i = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hA5A5_0001;
    clear_reqs();
    test_reset();
    test_single_read();
    test_contention();
    test_lock_rmw();
    test_write_then_read();
    test_idle();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
